// File: rtl/systolic_batch_scheduler.sv
// Batch scheduler in front of systolic_array: packs tagged dot-product jobs into unit slots,
// launches the batch once, waits for the active units, then drains results in slot order.
module systolic_batch_scheduler #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned MAX_LENGTH    = 64,
  parameter int unsigned NUM_UNITS     = 64,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned BATCH_TIMEOUT = 32,
  parameter int unsigned WAIT_LIMIT    = 4096
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    job_valid,
  output logic                                    job_ready,
  input  logic [$clog2(MAX_LENGTH)-1:0]           job_length,
  input  logic [ID_WIDTH-1:0]                     job_id,
  input  logic                                    flush,
  output logic                                    arr_start,
  output logic [NUM_UNITS-1:0]                    arr_active_units,
  output logic [NUM_UNITS*$clog2(MAX_LENGTH)-1:0] arr_length_array,
  input  logic [NUM_UNITS*WIDTH-1:0]              arr_result_array,
  input  logic [NUM_UNITS-1:0]                    arr_done_array,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [ID_WIDTH-1:0]                     res_id,
  output logic [$clog2(NUM_UNITS)-1:0]            res_unit,
  output logic [WIDTH-1:0]                        res_data,
  output logic                                    res_err,
  output logic                                    busy,
  output logic                                    timeout_err
);

  localparam int unsigned LenW  = $clog2(MAX_LENGTH);
  localparam int unsigned UnitW = $clog2(NUM_UNITS);
  localparam int unsigned CntW  = $clog2(NUM_UNITS + 1);
  localparam int unsigned TimW  = $clog2(BATCH_TIMEOUT + 1);
  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

  localparam logic [CntW-1:0]  FullCnt    = CntW'(NUM_UNITS);
  localparam logic [TimW-1:0]  TimeoutCnt = TimW'(BATCH_TIMEOUT);
  localparam logic [WaitW-1:0] WaitMax    = WaitW'(WAIT_LIMIT);

  typedef enum logic [2:0] {StIdle, StCollect, StLaunch, StWait, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [NUM_UNITS-1:0]      mask_q, mask_d;
  logic [NUM_UNITS*LenW-1:0] len_q, len_d;
  logic [NUM_UNITS*ID_WIDTH-1:0] id_q, id_d;
  logic [NUM_UNITS*WIDTH-1:0] res_q, res_d;
  logic [TimW-1:0]           timer_q, timer_d;
  logic [WaitW-1:0]          wait_q, wait_d;
  logic [UnitW-1:0]          slot_q, slot_d;
  logic                      start_q, start_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;
  logic                      accept;

  assign job_ready = ((state_q == StIdle) || (state_q == StCollect)) && (count_q != FullCnt);
  assign accept    = job_valid & job_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    len_d   = len_q;
    id_d    = id_q;
    res_d   = res_q;
    timer_d = timer_q;
    wait_d  = wait_q;
    slot_d  = slot_q;
    start_d = 1'b0;
    err_d   = err_q;
    tmo_d   = tmo_q;

    if (accept) begin
      id_d[count_q[UnitW-1:0]*ID_WIDTH +: ID_WIDTH] = job_id;
      len_d[count_q[UnitW-1:0]*LenW +: LenW]        = job_length;
      mask_d[count_q[UnitW-1:0]]                    = (job_length != '0);
      count_d                                       = count_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCollect;
          timer_d = '0;
        end
      end
      StCollect: begin
        timer_d = accept ? '0 : timer_q + TimW'(1);
        // Evaluated on post-accept values so a job arriving with flush joins this batch.
        if ((count_d == FullCnt) || flush || (timer_d == TimeoutCnt)) begin
          state_d = StLaunch;
          start_d = (mask_d != '0);
        end
      end
      StLaunch: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if ((arr_done_array & mask_q) == mask_q) begin
          state_d = StDrain;
          slot_d  = '0;
          err_d   = 1'b0;
          for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            res_d[k*WIDTH +: WIDTH] = mask_q[k] ? arr_result_array[k*WIDTH +: WIDTH] : '0;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
          if (wait_d == WaitMax) begin
            state_d = StDrain;
            slot_d  = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            res_d   = '0;
          end
        end
      end
      StDrain: begin
        if (res_ready) begin
          if (CntW'(slot_q) == count_q - CntW'(1)) begin
            state_d = StIdle;
            count_d = '0;
            mask_d  = '0;
            len_d   = '0;
            id_d    = '0;
            res_d   = '0;
            slot_d  = '0;
            err_d   = 1'b0;
          end else begin
            slot_d = slot_q + UnitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
      timer_q <= '0;
      wait_q  <= '0;
      slot_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      id_q    <= id_d;
      res_q   <= res_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign arr_start        = start_q;
  assign arr_active_units = mask_q;
  assign arr_length_array = len_q;
  assign res_valid        = (state_q == StDrain);
  assign res_id           = id_q[slot_q*ID_WIDTH +: ID_WIDTH];
  assign res_unit         = slot_q;
  assign res_data         = res_q[slot_q*WIDTH +: WIDTH];
  assign res_err          = err_q;
  assign busy             = (state_q != StIdle);
  assign timeout_err      = tmo_q;

endmodule

// File: tb/tb_systolic_batch_scheduler.sv
// Directed bench for systolic_batch_scheduler: a per-cycle batch model checks every output,
// and hand-computed values pin timing, masks and result contents for each scenario.
module tb_systolic_batch_scheduler;

  localparam int NU  = 64;
  localparam int LW  = 6;
  localparam int UW  = 6;
  localparam int IW  = 8;
  localparam int W   = 16;
  localparam int BT  = 32;
  localparam int WL  = 4096;
  localparam int CMW = NU * LW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [LW-1:0]      job_length = '0;
  logic [IW-1:0]      job_id = '0;
  logic               flush = 1'b0;
  logic               arr_start;
  logic [NU-1:0]      arr_active_units;
  logic [NU*LW-1:0]   arr_length_array;
  logic [NU*W-1:0]    arr_result_array = '0;
  logic [NU-1:0]      arr_done_array = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [IW-1:0]      res_id;
  logic [UW-1:0]      res_unit;
  logic [W-1:0]       res_data;
  logic               res_err;
  logic               busy;
  logic               timeout_err;

  systolic_batch_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_length       (job_length),
    .job_id           (job_id),
    .flush            (flush),
    .arr_start        (arr_start),
    .arr_active_units (arr_active_units),
    .arr_length_array (arr_length_array),
    .arr_result_array (arr_result_array),
    .arr_done_array   (arr_done_array),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_id           (res_id),
    .res_unit         (res_unit),
    .res_data         (res_data),
    .res_err          (res_err),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CMW-1:0] act, input logic [CMW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Array responder controls
  int        resp_lat = 4;
  bit        resp_never = 1'b0;
  bit        resp_flat = 1'b1;
  logic [W-1:0] resp_base = 16'h4600;
  int        gen = 0;
  bit        rr_mode = 1'b0;

  // Batch model
  logic [IW-1:0] m_id  [NU];
  logic [LW-1:0] m_len [NU];
  logic [W-1:0]  m_res [NU];
  int  m_n = 0, m_timer = 0, m_age = 0, m_wait = 0, m_slot = 0;
  bit  m_launched = 0, m_drain = 0, m_err = 0, m_tmo = 0;
  logic [NU-1:0] e_mask;
  logic [NU*LW-1:0] e_lens;
  logic [W-1:0] e_data;
  bit  e_ready, was, acc;

  // Observations used by the literal checks
  int t_start = 0, t_first = -1, t_acc = 0, n_res = 0, n_start = 0;
  logic [NU-1:0] st_mask = '0;
  logic [NU*LW-1:0] st_lens = '0;
  logic [W-1:0] got_data [NU];
  logic [IW-1:0] got_id [NU];
  logic got_err [NU];

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_n = 0; m_timer = 0; m_age = 0; m_wait = 0; m_slot = 0;
        m_launched = 0; m_drain = 0; m_err = 0; m_tmo = 0;
      end else begin
        e_mask = '0;
        e_lens = '0;
        for (int k = 0; k < m_n; k++) begin
          e_mask[k] = (m_len[k] != '0);
          e_lens[k*LW +: LW] = m_len[k];
        end
        e_ready = !m_launched && !m_drain && (m_n < NU);
        chk("busy", busy, (m_n > 0) || m_launched || m_drain);
        chk("job_ready", job_ready, e_ready);
        chk("arr_start", arr_start, m_launched && (m_age == 1) && (e_mask != '0));
        chk("res_valid", res_valid, m_drain);
        chk("timeout_err", timeout_err, m_tmo);
        if (m_launched || m_drain) begin
          chk("arr_active_units", arr_active_units, e_mask);
          chk("arr_length_array", arr_length_array, e_lens);
        end
        if (m_drain) begin
          e_data = (m_err || (m_len[m_slot] == '0)) ? '0 : m_res[m_slot];
          chk("res_id", res_id, m_id[m_slot]);
          chk("res_unit", res_unit, m_slot);
          chk("res_data", res_data, e_data);
          chk("res_err", res_err, m_err);
        end

        if (arr_start) begin
          t_start = cyc; t_first = -1; n_start++;
          st_mask = arr_active_units; st_lens = arr_length_array;
        end
        if (res_valid && t_first < 0) t_first = cyc;

        if (m_drain) begin
          if (res_ready) begin
            got_data[m_slot] = res_data; got_id[m_slot] = res_id; got_err[m_slot] = res_err;
            n_res++;
            m_slot++;
            if (m_slot == m_n) begin
              m_drain = 0; m_n = 0;
            end
          end
        end else if (m_launched) begin
          if (m_age == 1) begin
            m_age = 2; m_wait = 0;
          end else if ((arr_done_array & e_mask) == e_mask) begin
            for (int k = 0; k < NU; k++) m_res[k] = arr_result_array[k*W +: W];
            m_drain = 1; m_launched = 0; m_slot = 0; m_err = 0;
          end else begin
            m_wait++;
            if (m_wait == WL) begin
              m_drain = 1; m_launched = 0; m_slot = 0; m_err = 1; m_tmo = 1;
            end
          end
        end else begin
          was = (m_n > 0);
          acc = job_valid && e_ready;
          if (acc) begin
            m_id[m_n] = job_id; m_len[m_n] = job_length; m_n++; t_acc = cyc;
          end
          if (was) begin
            m_timer = acc ? 0 : m_timer + 1;
            if ((m_n == NU) || flush || (m_timer == BT)) begin
              m_launched = 1; m_age = 1;
            end
          end else begin
            m_timer = 0;
          end
        end
      end
    end
  end

  // Systolic array stand-in: done for the active units resp_lat cycles after the start edge.
  initial begin
    int g;
    logic [NU-1:0] m;
    forever begin
      @(negedge clk);
      if (arr_start && !reset) begin
        g = gen;
        m = arr_active_units;
        arr_done_array = '0;
        if (!resp_never) begin
          repeat (resp_lat + 1) @(posedge clk);
          #1;
          if (g == gen) begin
            for (int k = 0; k < NU; k++)
              arr_result_array[k*W +: W] = resp_flat ? resp_base : resp_base + W'(k);
            arr_done_array = m;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_mode ? ~res_ready : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [IW-1:0] id, input logic [LW-1:0] len, input bit fl);
    int n = 0;
    job_valid = 1'b1; job_id = id; job_length = len; flush = fl;
    @(negedge clk);
    while (!job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_job accepted", job_ready, 1'b1);
    step();
    job_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached at cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    int a3, s0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst job_ready", job_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst mask", arr_active_units, '0);
    step();

    // flush with nothing collected does nothing
    flush = 1'b1; step(); flush = 1'b0;
    @(negedge clk);
    chk("idle flush busy", busy, 1'b0);
    step();

    // 1: four length-3 jobs, flush, results 0x4600
    n_res = 0;
    for (int i = 0; i < 4; i++) send_job(8'hA0 + 8'(i), 6'd3, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(200, "t1 drain");
    chk("t1 results", n_res, 4);
    chk("t1 mask", st_mask, 64'hF);
    chk("t1 len slot3", st_lens[3*LW +: LW], 6'd3);
    chk("t1 latency", t_first - t_start, resp_lat + 2);
    chk("t1 data0", got_data[0], 16'h4600);
    chk("t1 id3", got_id[3], 8'hA3);

    // 2: full batch auto-launches
    n_res = 0; resp_flat = 1'b0; resp_base = 16'h3C00; resp_lat = 2;
    for (int i = 0; i < NU; i++) send_job(IW'(i), LW'((i % 7) + 1), 1'b0);
    wait_idle(500, "t2 drain");
    chk("t2 results", n_res, NU);
    chk("t2 start after full", t_start - t_acc, 1);
    chk("t2 mask", st_mask, {NU{1'b1}});
    chk("t2 data63", got_data[63], 16'h3C3F);

    // 3: idle timer launch, restarted by a job at timer 31
    n_res = 0;
    send_job(8'hC0, 6'd2, 1'b0);
    send_job(8'hC1, 6'd4, 1'b0);
    repeat (31) step();
    send_job(8'hC2, 6'd1, 1'b0);
    a3 = t_acc;
    wait_idle(200, "t3 drain");
    chk("t3 timeout launch", t_start - a3, BT + 1);
    chk("t3 results", n_res, 3);

    // 4: zero-length slot, job together with flush
    n_res = 0; resp_base = 16'h5000;
    send_job(8'hD0, 6'd3, 1'b0);
    send_job(8'hD1, 6'd0, 1'b0);
    send_job(8'hD2, 6'd5, 1'b1);
    wait_idle(200, "t4 drain");
    chk("t4 results", n_res, 3);
    chk("t4 mask", st_mask, 64'h5);
    chk("t4 len slot1", st_lens[LW +: LW], 6'd0);
    chk("t4 len slot2", st_lens[2*LW +: LW], 6'd5);
    chk("t4 data0", got_data[0], 16'h5000);
    chk("t4 data1", got_data[1], 16'h0000);
    chk("t4 data2", got_data[2], 16'h5002);
    // all-zero batch: no start pulse, one zero result
    n_res = 0; s0 = n_start;
    send_job(8'hD3, 6'd0, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(50, "t4z drain");
    chk("t4z no start", n_start, s0);
    chk("t4z results", n_res, 1);
    chk("t4z id", got_id[0], 8'hD3);

    // 5: watchdog
    n_res = 0; resp_never = 1'b1;
    send_job(8'hE0, 6'd2, 1'b0);
    send_job(8'hE1, 6'd7, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(WL + 300, "t5 drain");
    chk("t5 results", n_res, 2);
    chk("t5 wd latency", t_first - t_start, WL + 1);
    chk("t5 err0", got_err[0], 1'b1);
    chk("t5 err1", got_err[1], 1'b1);
    chk("t5 data1", got_data[1], 16'h0000);
    repeat (5) step();
    chk("t5 sticky", timeout_err, 1'b1);

    // 6: stalled drain, then reset mid-WAIT, then a clean batch
    n_res = 0; resp_never = 1'b0; resp_lat = 3; resp_base = 16'h4000; rr_mode = 1'b1;
    for (int i = 0; i < 5; i++) send_job(8'hF0 + 8'(i), LW'(i + 1), 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(200, "t6 drain");
    rr_mode = 1'b0;
    chk("t6 results", n_res, 5);
    chk("t6 id4", got_id[4], 8'hF4);
    chk("t6 data4", got_data[4], 16'h4004);

    resp_lat = 50;
    send_job(8'h11, 6'd9, 1'b0);
    send_job(8'h12, 6'd9, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    repeat (10) step();
    reset = 1'b1; gen++; arr_done_array = '0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst job_ready", job_ready, 1'b1);
    chk("t6 rst res_valid", res_valid, 1'b0);
    chk("t6 rst timeout_err", timeout_err, 1'b0);
    chk("t6 rst mask", arr_active_units, '0);
    chk("t6 rst lens", arr_length_array, '0);
    step();
    repeat (60) step();

    n_res = 0; resp_lat = 1; resp_base = 16'h2000;
    for (int i = 0; i < 3; i++) send_job(8'h20 + 8'(i), 6'd4, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(200, "t6b drain");
    chk("t6b results", n_res, 3);
    chk("t6b mask", st_mask, 64'h7);
    chk("t6b data2", got_data[2], 16'h2002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
